// File: rtl/bfly_router_radix.sv
// Radix x Radix butterfly routing primitive: per-output round-robin arbitration and a
// fixed-latency response return pipeline. Define BFLY_ROUTER_RADIX_PRIO_EN for prio_i arbitration.
module bfly_router_radix #(
  parameter int unsigned Radix         = 4,
  parameter int unsigned NumLevels     = 4,
  parameter int unsigned ReqDataWidth  = 32,
  parameter int unsigned RespDataWidth = 32,
  parameter int unsigned RespLatency   = 1,
  parameter int unsigned SelWidth      = $clog2(Radix)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [Radix-1:0]                        req_i,
  output logic [Radix-1:0]                        gnt_o,
  input  logic [Radix-1:0][SelWidth-1:0]          sel_i,
  input  logic [Radix-1:0]                        prio_i,
  input  logic [Radix-1:0][NumLevels-1:0]         add_i,
  input  logic [Radix-1:0][ReqDataWidth-1:0]      data_i,
  output logic [Radix-1:0][RespDataWidth-1:0]     rdata_o,
  output logic [Radix-1:0]                        rvalid_o,
  output logic [Radix-1:0]                        req_o,
  input  logic [Radix-1:0]                        gnt_i,
  output logic [Radix-1:0][NumLevels-1:0]         add_o,
  output logic [Radix-1:0][ReqDataWidth-1:0]      data_o,
  input  logic [Radix-1:0][RespDataWidth-1:0]     rdata_i
);

  // tgt[o][i]: input i currently requests output o
  logic [Radix-1:0][Radix-1:0]                       tgt;
  logic [Radix-1:0][Radix-1:0]                       cand;
  logic [Radix-1:0][SelWidth-1:0]                    win;
  logic [Radix-1:0]                                  any;
  logic [Radix-1:0]                                  fire;
  logic [Radix-1:0][SelWidth-1:0]                    ptr_q, ptr_d;
  logic [Radix-1:0][RespLatency-1:0]                 vld_q;
  logic [Radix-1:0][RespLatency-1:0][SelWidth-1:0]   idx_q;

  always_comb begin
    tgt = '0;
    for (int unsigned o = 0; o < Radix; o++) begin
      for (int unsigned i = 0; i < Radix; i++) begin
        tgt[o][i] = req_i[i] && (sel_i[i] == SelWidth'(o));
      end
    end
  end

`ifdef BFLY_ROUTER_RADIX_PRIO_EN
  always_comb begin
    cand = '0;
    for (int unsigned o = 0; o < Radix; o++) begin
      cand[o] = (|(tgt[o] & prio_i)) ? (tgt[o] & prio_i) : tgt[o];
    end
  end
`else
  assign cand = tgt;
  logic unused_prio;
  assign unused_prio = ^prio_i;
`endif

  // First candidate at or after the pointer, wrapping
  always_comb begin
    logic                found;
    logic [SelWidth-1:0] w;
    logic [SelWidth-1:0] idx;
    win = '0;
    any = '0;
    for (int unsigned o = 0; o < Radix; o++) begin
      found = 1'b0;
      w     = '0;
      for (int unsigned k = 0; k < Radix; k++) begin
        idx = SelWidth'((32'(ptr_q[o]) + k) % Radix);
        if (!found && cand[o][idx]) begin
          found = 1'b1;
          w     = idx;
        end
      end
      win[o] = w;
      any[o] = found;
    end
  end

  always_comb begin
    req_o  = '0;
    add_o  = '0;
    data_o = '0;
    gnt_o  = '0;
    fire   = '0;
    ptr_d  = ptr_q;
    for (int unsigned o = 0; o < Radix; o++) begin
      req_o[o] = |tgt[o];
      if (any[o]) begin
        add_o[o]  = add_i[win[o]];
        data_o[o] = data_i[win[o]];
      end
      fire[o] = any[o] & gnt_i[o];
      if (fire[o]) begin
        gnt_o[win[o]] = 1'b1;
        ptr_d[o] = (win[o] == SelWidth'(Radix - 1)) ? '0 : win[o] + SelWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int unsigned o = 0; o < Radix; o++) begin
        vld_q[o][0] <= fire[o];
        idx_q[o][0] <= win[o];
        for (int unsigned s = 1; s < RespLatency; s++) begin
          vld_q[o][s] <= vld_q[o][s-1];
          idx_q[o][s] <= idx_q[o][s-1];
        end
      end
    end
  end

  // An input is granted on at most one output per cycle, so tail matches never collide
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    for (int unsigned o = 0; o < Radix; o++) begin
      if (vld_q[o][RespLatency-1]) begin
        rvalid_o[idx_q[o][RespLatency-1]] = 1'b1;
        rdata_o[idx_q[o][RespLatency-1]]  = rdata_i[o];
      end
    end
  end

endmodule

// File: tb/tb_bfly_router_radix.sv
// Bench for bfly_router_radix: directed scenarios plus randomized traffic against a
// behavioural model, on two instances (response latency 1 and 3).
module tb_bfly_router_radix;
  localparam int R  = 4;
  localparam int NL = 4;
  localparam int DW = 32;
  localparam int RW = 32;

  logic clk = 1'b0;
  logic rst;
  logic [R-1:0]          req, prio, gnt_in;
  logic [R-1:0][1:0]     sel;
  logic [R-1:0][NL-1:0]  add;
  logic [R-1:0][DW-1:0]  data;
  logic [R-1:0][RW-1:0]  rdata_in;

  logic [R-1:0]          gnt1, rvalid1, req1, gnt3, rvalid3, req3;
  logic [R-1:0][NL-1:0]  add1, add3;
  logic [R-1:0][DW-1:0]  data1, data3;
  logic [R-1:0][RW-1:0]  rdata1, rdata3;

  always #5 clk = ~clk;

  bfly_router_radix #(.Radix(R), .NumLevels(NL), .ReqDataWidth(DW), .RespDataWidth(RW),
                      .RespLatency(1)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt1), .sel_i(sel), .prio_i(prio),
    .add_i(add), .data_i(data), .rdata_o(rdata1), .rvalid_o(rvalid1), .req_o(req1),
    .gnt_i(gnt_in), .add_o(add1), .data_o(data1), .rdata_i(rdata_in)
  );

  bfly_router_radix #(.Radix(R), .NumLevels(NL), .ReqDataWidth(DW), .RespDataWidth(RW),
                      .RespLatency(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt3), .sel_i(sel), .prio_i(prio),
    .add_i(add), .data_i(data), .rdata_o(rdata3), .rvalid_o(rvalid3), .req_o(req3),
    .gnt_i(gnt_in), .add_o(add3), .data_o(data3), .rdata_i(rdata_in)
  );

  int checks = 0;
  int failures = 0;

  // Model state: arbitration pointers and a log of grants per cycle
  int m_ptr[R];
  int cyc = 0;
  bit rv[16][R];
  int ri[16][R];
  int m_win[R];
  bit m_any[R];
  logic [R-1:0]          exp_req, exp_gnt, exp_rv1, exp_rv3;
  logic [R-1:0][NL-1:0]  exp_add;
  logic [R-1:0][DW-1:0]  exp_data;
  logic [R-1:0][RW-1:0]  exp_rd1, exp_rd3;

  function automatic void model_eval();
    exp_req = '0; exp_gnt = '0; exp_add = '0; exp_data = '0;
    exp_rv1 = '0; exp_rd1 = '0; exp_rv3 = '0; exp_rd3 = '0;
    for (int o = 0; o < R; o++) begin
      bit hasp;
      hasp = 1'b0;
      m_any[o] = 1'b0;
      m_win[o] = 0;
`ifdef BFLY_ROUTER_RADIX_PRIO_EN
      for (int i = 0; i < R; i++) if (req[i] && int'(sel[i]) == o && prio[i]) hasp = 1'b1;
`endif
      for (int k = 0; k < R; k++) begin
        int i;
        i = (m_ptr[o] + k) % R;
        if (!m_any[o] && req[i] && int'(sel[i]) == o && (!hasp || prio[i])) begin
          m_any[o] = 1'b1;
          m_win[o] = i;
        end
      end
      if (m_any[o]) begin
        exp_req[o]  = 1'b1;
        exp_add[o]  = add[m_win[o]];
        exp_data[o] = data[m_win[o]];
        if (gnt_in[o]) exp_gnt[m_win[o]] = 1'b1;
      end
    end
    for (int o = 0; o < R; o++) begin
      if (cyc >= 1 && rv[(cyc - 1) % 16][o]) begin
        exp_rv1[ri[(cyc - 1) % 16][o]] = 1'b1;
        exp_rd1[ri[(cyc - 1) % 16][o]] = rdata_in[o];
      end
      if (cyc >= 3 && rv[(cyc - 3) % 16][o]) begin
        exp_rv3[ri[(cyc - 3) % 16][o]] = 1'b1;
        exp_rd3[ri[(cyc - 3) % 16][o]] = rdata_in[o];
      end
    end
  endfunction

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst) begin
      for (int o = 0; o < R; o++) m_ptr[o] = 0;
      for (int c = 0; c < 16; c++) for (int o = 0; o < R; o++) rv[c][o] = 1'b0;
    end else begin
      for (int o = 0; o < R; o++) begin
        rv[cyc % 16][o] = m_any[o] && gnt_in[o];
        ri[cyc % 16][o] = m_win[o];
        if (rv[cyc % 16][o]) m_ptr[o] = (m_win[o] + 1) % R;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    req = '0; prio = '0; gnt_in = '0; sel = '0; add = '0; data = '0; rdata_in = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    req[0] = 1'b1; sel[0] = 2'd2; gnt_in[2] = 1'b1;
    @(negedge clk);
    checks++; if (gnt1 !== 4'b0001) begin failures++;
      $display("FAIL reset_comb_gnt got=%b exp=%b", gnt1, 4'b0001); end
    checks++; if (req1 !== 4'b0100) begin failures++;
      $display("FAIL reset_comb_req got=%b exp=%b", req1, 4'b0100); end
    tick();
    idle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rvalid1 !== '0 || rvalid3 !== '0) begin failures++;
      $display("FAIL reset_rvalid got=%b/%b exp=0", rvalid1, rvalid3); end
    checks++; if (rdata1 !== '0 || rdata3 !== '0) begin failures++;
      $display("FAIL reset_rdata got=%h exp=0", rdata1); end
    checks++; if (req1 !== '0 || add1 !== '0 || data1 !== '0) begin failures++;
      $display("FAIL reset_idle_out got req=%b add=%h data=%h exp=0", req1, add1, data1); end
    tick();
  endtask

  task automatic test_permutation();
    do_reset();
    sel[0] = 2'd2; sel[1] = 2'd3; sel[2] = 2'd0; sel[3] = 2'd1;
    req = 4'b1111; gnt_in = 4'b1111;
    for (int i = 0; i < R; i++) begin data[i] = $urandom; add[i] = NL'($urandom); end
    @(negedge clk);
    checks++; if (gnt1 !== 4'b1111) begin failures++;
      $display("FAIL perm_gnt got=%b exp=%b", gnt1, 4'b1111); end
    checks++; if (data1[2] !== data[0] || data1[1] !== data[3]) begin failures++;
      $display("FAIL perm_data got=%h/%h exp=%h/%h", data1[2], data1[1], data[0], data[3]); end
    tick();
    idle();
    for (int o = 0; o < R; o++) rdata_in[o] = $urandom;
    @(negedge clk);
    checks++; if (rvalid1 !== 4'b1111) begin failures++;
      $display("FAIL perm_rvalid got=%b exp=%b", rvalid1, 4'b1111); end
    checks++; if (rdata1[0] !== rdata_in[2] || rdata1[3] !== rdata_in[1]) begin failures++;
      $display("FAIL perm_rdata got=%h/%h exp=%h/%h", rdata1[0], rdata1[3], rdata_in[2],
               rdata_in[1]); end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 4'b1111; sel = {2'd1, 2'd1, 2'd1, 2'd1}; gnt_in = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      rdata_in[1] = $urandom;
      @(negedge clk);
      checks++; if (gnt1 !== 4'(1 << (k % 4))) begin failures++;
        $display("FAIL rr_gnt%0d got=%b exp=%b", k, gnt1, 4'(1 << (k % 4))); end
      if (k > 0) begin
        checks++; if (rvalid1 !== 4'(1 << ((k - 1) % 4)) || rdata1[(k - 1) % 4] !== rdata_in[1])
        begin failures++;
          $display("FAIL rr_resp%0d got=%b exp=%b", k, rvalid1, 4'(1 << ((k - 1) % 4))); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    req = 4'b1110; gnt_in = 4'b0001;
    @(negedge clk);
    checks++; if (gnt1 !== 4'b0010) begin failures++;
      $display("FAIL stall_first got=%b exp=%b", gnt1, 4'b0010); end
    tick();
    req = 4'b1011; gnt_in = 4'b0000;
    for (int i = 0; i < R; i++) data[i] = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (gnt1 !== 4'b0000 || req1[0] !== 1'b1 || data1[0] !== data[3]) begin
        failures++;
        $display("FAIL stall_hold%0d got gnt=%b data=%h exp gnt=0000 data=%h", k, gnt1,
                 data1[0], data[3]); end
      tick();
    end
    gnt_in = 4'b0001;
    @(negedge clk);
    checks++; if (gnt1 !== 4'b1000) begin failures++;
      $display("FAIL stall_release got=%b exp=%b", gnt1, 4'b1000); end
    tick();
    @(negedge clk);
    checks++; if (gnt1 !== 4'b0001) begin failures++;
      $display("FAIL stall_after got=%b exp=%b", gnt1, 4'b0001); end
    tick();
  endtask

  task automatic test_latency3();
    do_reset();
    req[2] = 1'b1; sel[2] = 2'd3; gnt_in = 4'b1111;
    @(negedge clk);
    checks++; if (gnt3 !== 4'b0100) begin failures++;
      $display("FAIL lat3_gnt got=%b exp=%b", gnt3, 4'b0100); end
    tick();
    idle();
    for (int d = 1; d <= 3; d++) begin
      rdata_in[3] = $urandom;
      @(negedge clk);
      if (d == 1) begin
        checks++; if (rvalid1 !== 4'b0100) begin failures++;
          $display("FAIL lat1_rvalid got=%b exp=%b", rvalid1, 4'b0100); end
      end
      if (d < 3) begin
        checks++; if (rvalid3 !== 4'b0000) begin failures++;
          $display("FAIL lat3_early%0d got=%b exp=0000", d, rvalid3); end
      end else begin
        checks++; if (rvalid3 !== 4'b0100 || rdata3[2] !== rdata_in[3]) begin failures++;
          $display("FAIL lat3_resp got=%b/%h exp=0100/%h", rvalid3, rdata3[2], rdata_in[3]); end
      end
      tick();
    end
    req[2] = 1'b1; sel[2] = 2'd3; gnt_in = 4'b1111;
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 2; d <= 3; d++) begin
      @(negedge clk);
      checks++; if (rvalid3 !== 4'b0000) begin failures++;
        $display("FAIL lat3_flush%0d got=%b exp=0000", d, rvalid3); end
      tick();
    end
  endtask

  task automatic test_prio();
    logic [R-1:0] exp;
    do_reset();
    req = 4'b0011; prio = 4'b0010; gnt_in = 4'b0001;
`ifdef BFLY_ROUTER_RADIX_PRIO_EN
    exp = 4'b0010;
`else
    exp = 4'b0001;
`endif
    @(negedge clk);
    checks++; if (gnt1 !== exp) begin failures++;
      $display("FAIL prio_gnt got=%b exp=%b", gnt1, exp); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 39) == 0);
      req    = 4'($urandom);
      sel    = 8'($urandom);
      prio   = 4'($urandom);
      gnt_in = 4'($urandom);
      add    = 16'($urandom);
      for (int i = 0; i < R; i++) begin data[i] = $urandom; rdata_in[i] = $urandom; end
      @(negedge clk);
      model_eval();
      checks++; if (gnt1 !== exp_gnt || gnt3 !== exp_gnt) begin failures++;
        $display("FAIL rnd_gnt n=%0d got=%b/%b exp=%b", n, gnt1, gnt3, exp_gnt); end
      checks++; if (req1 !== exp_req || req3 !== exp_req) begin failures++;
        $display("FAIL rnd_req n=%0d got=%b exp=%b", n, req1, exp_req); end
      checks++; if (add1 !== exp_add || data1 !== exp_data || data3 !== exp_data) begin
        failures++;
        $display("FAIL rnd_fwd n=%0d got=%h/%h exp=%h/%h", n, add1, data1, exp_add, exp_data); end
      checks++; if (rvalid1 !== exp_rv1 || rdata1 !== exp_rd1) begin failures++;
        $display("FAIL rnd_resp1 n=%0d got=%b exp=%b", n, rvalid1, exp_rv1); end
      checks++; if (rvalid3 !== exp_rv3 || rdata3 !== exp_rd3) begin failures++;
        $display("FAIL rnd_resp3 n=%0d got=%b exp=%b", n, rvalid3, exp_rv3); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < 16; c++) for (int o = 0; o < R; o++) begin rv[c][o] = 1'b0; ri[c][o] = 0; end
    for (int o = 0; o < R; o++) m_ptr[o] = 0;
    rst = 1'b1;
    idle();
    #1;
    test_reset();
    test_permutation();
    test_round_robin();
    test_stall();
    test_latency3();
    test_prio();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bfly_router_radix.md
Name: bfly_router_radix

Overview:
- Radix-R routing primitive for multi-stage butterfly interconnects. Generalises the 2x2 router to Radix inputs x Radix outputs.
- Adds a per-output round-robin arbiter with stored state.
- Adds a configurable response pipeline depth, and a response-valid per input.
- Sits at each stage of the low-latency TCDM interconnect, between initiator-side and bank-side stages.

Parameters:
- Radix, 4, number of input ports and output ports; must be >= 2.
- NumLevels, 4, width of the forwarded address field.
- ReqDataWidth, 32, width of the request payload.
- RespDataWidth, 32, width of the response payload.
- RespLatency, 1, cycles from grant to rdata_i at the outputs; legal range 1..4.
- SelWidth, $clog2(Radix), derived; do not override.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  [Radix-1:0]  per-input request.
- gnt_o  out  [Radix-1:0]  per-input grant.
- sel_i  in  [Radix-1:0][SelWidth-1:0]  target output index per input.
- prio_i  in  [Radix-1:0]  priority flag per input; used only with the optional feature.
- add_i  in  [Radix-1:0][NumLevels-1:0]  per-input address.
- data_i  in  [Radix-1:0][ReqDataWidth-1:0]  per-input payload.
- rdata_o  out  [Radix-1:0][RespDataWidth-1:0]  per-input response data.
- rvalid_o  out  [Radix-1:0]  per-input response valid.
- req_o  out  [Radix-1:0]  per-output request.
- gnt_i  in  [Radix-1:0]  per-output grant.
- add_o  out  [Radix-1:0][NumLevels-1:0]  per-output address.
- data_o  out  [Radix-1:0][ReqDataWidth-1:0]  per-output payload.
- rdata_i  in  [Radix-1:0][RespDataWidth-1:0]  per-output response data.

Behaviour:
- Request side is combinational, with zero latency.
- Input i targets output o when req_i[i]=1 and sel_i[i]=o.
- If sel_i[i] >= Radix, the request is ignored: gnt_o[i]=0 and it never raises req_o.
- req_o[o] = OR of all inputs targeting o. req_o never depends on gnt_i (no combinational loop gnt_i->req_o).
- Per-output winner w(o): the first targeting input found scanning from ptr_q[o] upward, wrapping modulo Radix.
- add_o[o] and data_o[o] come from w(o). When no input targets o, they are driven '0.
- gnt_o[i] = gnt_i[o] & (i == w(o)), where o = sel_i[i]. Non-winners get gnt_o=0 and must hold their request.
- Arbiter state ptr_q[o] (SelWidth bits per output):
  - On req_o[o] & gnt_i[o]: ptr_q[o] <= (w(o)+1) mod Radix.
  - Otherwise ptr_q[o] holds.
  - An ungranted winner keeps priority, so no starvation while gnt_i eventually asserts.
- Response tracking, per output: shift register of depth RespLatency. Each entry is {valid, idx}.
  - Entry 0 loads {req_o[o] & gnt_i[o], w(o)} every cycle.
  - Entries shift every cycle unconditionally (no stall).
  - Tail entry at stage RespLatency-1 = T[o].
- rvalid_o[i] = 1 when some output o has T[o].valid and T[o].idx == i.
  - rdata_o[i] = rdata_i[o] for that o; otherwise '0.
  - At most one output matches per input per cycle, since an input is granted on at most one output per cycle.
- Back-to-back grants on one output from different inputs return in grant order, one per cycle.
- Simultaneous events:
  - All Radix inputs targeting distinct outputs are all granted in the same cycle when every gnt_i=1.
  - Radix inputs on one output are served in round-robin order, one per granted cycle.
- Reset (rst_i=1 at a clock edge): ptr_q all 0 and all pipeline valid bits 0.
  - From the next cycle rvalid_o=0 and rdata_o='0.
  - Responses in flight are dropped.
  - Combinational outputs still follow their inputs during reset.

Optional Feature:
- Macro: BFLY_ROUTER_RADIX_PRIO_EN.
- Defined: per output, if any targeting input has prio_i=1, arbitration is round-robin among the prio_i=1 inputs only, using the same ptr_q[o]. Otherwise plain round-robin. The pointer update rule is unchanged.
- Not defined: prio_i is ignored, with no logic on it; pure round-robin. The port stays present in both builds for a uniform interface.

Test Plan:
- Radix=4, RespLatency=1, reset then idle -> rvalid_o=0, req_o=0, add_o/data_o=0.
- Permutation: inputs 0..3 with sel 2,3,0,1, all gnt_i=1 -> gnt_o=4'b1111 same cycle. Next cycle rvalid_o=4'b1111, with rdata_o[0]=rdata_i[2] and rdata_o[3]=rdata_i[1].
- All 4 inputs target output 1 with gnt_i[1]=1 for 4 cycles -> gnt_o=0001, 0010, 0100, 1000; ptr_q[1] ends at 0; responses return in that order.
- Contention on output 0 with gnt_i[0]=0 for 3 cycles, then 1 -> winner input stays the same throughout; ptr_q[0] unchanged until the grant.
- RespLatency=3, single grant input 2 -> output 3 at cycle t -> rvalid_o[2]=1 only at t+3, rdata_o[2]=rdata_i[3]. Assert rst_i at t+1 -> no rvalid_o at t+3.
- With BFLY_ROUTER_RADIX_PRIO_EN, inputs 0 and 1 on output 0, prio_i=2'b10, ptr_q[0]=0 -> input 1 granted first. Without the macro -> input 0 granted first.
